// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA operand entry path: FSM state codes,
// opcode encodings and the opcode legality rule.
package ula_pkg;

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_OP   = 2'd2,
      S_SHOW = 2'd3
   } state_t;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_MUL  = 3'd4;
   localparam logic [2:0] OP_DIV  = 3'd5;
   localparam logic [2:0] OP_LAST = 3'd5;

   // Codes above OP_LAST and divide-by-zero never reach the ULA.
   function automatic logic op_legal(input logic [2:0] op, input logic [3:0] b);
      return (op <= OP_LAST) && !((op == OP_DIV) && (b == 4'd0));
   endfunction

endpackage

// File: rtl/ula_debounce.sv
// ENTER conditioning: 2-flop synchronizer, optional debounce counter
// (ULA_LOADER_DEBOUNCE_EN) and a registered one-cycle rising-edge press pulse.
module ula_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
      $error("ula_debounce: DEBOUNCE_CYCLES must be at least 2");
   end

   logic sync1_q, sync2_q;
   logic stable_q, stable_d;
   logic press_q, press_d;

`ifdef ULA_LOADER_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Any cycle where the input agrees with the stable level restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = ~stable_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   always_comb begin
      stable_d = sync2_q;
   end
`endif

   always_comb begin
      press_d = stable_d & ~stable_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= btn_raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         press_q  <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/ula_operand_loader.sv
// Captures A, B and opcode from shared switches over successive ENTER presses
// and holds them for the ULA. Debounce is built only with ULA_LOADER_DEBOUNCE_EN.
module ula_operand_loader
   import ula_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw,
   input  logic       btn_enter,
   input  logic       btn_clear,
   output logic [3:0] a_out,
   output logic [3:0] b_out,
   output logic [2:0] sel_out,
   output logic       operands_valid,
   output logic [1:0] stage,
   output logic       op_err
);

   logic   press;
   logic   clr_sync1_q, clr_sync2_q;
   state_t state_q, state_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [2:0] sel_q, sel_d;
   logic       valid_q, valid_d;
   logic       op_err_q, op_err_d;
   logic       op_ok;

   ula_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_enter (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_enter),
      .press   (press)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_sync1_q <= 1'b0;
         clr_sync2_q <= 1'b0;
      end else begin
         clr_sync1_q <= btn_clear;
         clr_sync2_q <= clr_sync1_q;
      end
   end

   assign op_ok = op_legal(sw[2:0], b_q);

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_A;
         a_q      <= '0;
         b_q      <= '0;
         sel_q    <= '0;
         valid_q  <= 1'b0;
         op_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         op_err_q <= op_err_d;
      end
   end

   // Next state; CLEAR wins over a same-cycle press.
   always_comb begin
      state_d = state_q;
      if (clr_sync2_q) begin
         state_d = S_A;
      end else if (press) begin
         case (state_q)
            S_A:     state_d = S_B;
            S_B:     state_d = S_OP;
            S_OP:    state_d = op_ok ? S_SHOW : S_OP;
            S_SHOW:  state_d = S_A;
            default: state_d = S_A;
         endcase
      end
   end

   // Field capture; leaving SHOW keeps the fields so the display stays put.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      sel_d    = sel_q;
      op_err_d = 1'b0;
      if (clr_sync2_q) begin
         a_d   = '0;
         b_d   = '0;
         sel_d = '0;
      end else if (press) begin
         case (state_q)
            S_A: a_d = sw;
            S_B: b_d = sw;
            S_OP: begin
               if (op_ok) begin
                  sel_d = sw[2:0];
               end else begin
                  op_err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
      valid_d = (state_d == S_SHOW);
   end

   assign a_out          = a_q;
   assign b_out          = b_q;
   assign sel_out        = sel_q;
   assign operands_valid = valid_q;
   assign stage          = state_q;
   assign op_err         = op_err_q;

endmodule
